// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: fetch FSM encoding, NOP word, opcode field
// bounds and the primary opcodes decoded by the main control unit.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } if_state_t;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam int          OPCODE_MSB = 31;
  localparam int          OPCODE_LSB = 26;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Fetch program counter: holds the PC, forms PC+4 (mod 2^32) and selects the
// next PC, with a word-aligned redirect target taking priority over advance.
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        load,
  input  logic [31:0] target,
  output logic [31:0] pc_next,
  output logic [31:0] pc_plus4
);

  logic [31:0] pc_r;

  assign pc_plus4 = pc_r + 32'd4;

  // next-PC select: redirect beats sequential advance
  always_comb begin
    pc_next = pc_r;
    if (load) begin
      pc_next = word_align(target);
    end else if (inc) begin
      pc_next = pc_plus4;
    end else begin
      pc_next = pc_r;
    end
  end

  // PC register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_next;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: request/ack instruction-memory handshake, redirect
// handling and a registered instruction slot. Optional IF_PERF_CNT_EN adds counters.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC         = 32'h0000_0000,
  parameter int          IMEM_LATENCY_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4,
  output logic [5:0]  if_opcode
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  if_state_t   state_r;
  logic        capture_s;
  logic        redir_s;
  logic [31:0] pc_next_s;
  logic [31:0] pc_plus4_s;

  // A capture is an ack in REQ that is not cancelled by a same-cycle redirect.
  assign capture_s = (state_r == ST_REQ) & imem_ack & ~redirect_valid;
  // IDLE ignores redirects so the first fetch is always RESET_PC.
  assign redir_s   = redirect_valid & (state_r != ST_IDLE);
  assign if_opcode = if_instr[OPCODE_MSB:OPCODE_LSB];

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (capture_s),
    .load     (redir_s),
    .target   (redirect_pc),
    .pc_next  (pc_next_s),
    .pc_plus4 (pc_plus4_s)
  );

  // fetch FSM with registered request and address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r   <= ST_REQ;
          imem_req  <= 1'b1;
          imem_addr <= pc_next_s;
        end
        ST_REQ: begin
          if (imem_ack) begin
            imem_addr <= pc_next_s;
            if (redirect_valid || !stall) begin
              state_r  <= ST_REQ;
              imem_req <= 1'b1;
            end else begin
              state_r  <= ST_HOLD;
              imem_req <= 1'b0;
            end
          end else if (redirect_valid) begin
            // address stays on the outstanding request until its ack
            state_r  <= ST_DROP;
            imem_req <= 1'b1;
          end else begin
            state_r  <= ST_REQ;
            imem_req <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (redirect_valid || !stall) begin
            state_r   <= ST_REQ;
            imem_req  <= 1'b1;
            imem_addr <= pc_next_s;
          end else begin
            state_r  <= ST_HOLD;
            imem_req <= 1'b0;
          end
        end
        ST_DROP: begin
          imem_req <= 1'b1;
          if (imem_ack) begin
            state_r   <= ST_REQ;
            imem_addr <= pc_next_s;
          end else begin
            state_r <= ST_DROP;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          imem_req  <= 1'b0;
          imem_addr <= RESET_PC;
        end
      endcase
    end
  end

  // instruction slot: redirect flush, capture, consume, or hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
      if_pc4   <= 32'h0000_0000;
    end else if (redirect_valid) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
    end else if (capture_s) begin
      if_valid <= 1'b1;
      if_instr <= imem_rdata;
      if_pc4   <= pc_plus4_s;
    end else if (if_valid && !stall) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
    end else begin
      if_valid <= if_valid;
    end
  end

`ifdef IF_PERF_CNT_EN
  // wrapping performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (capture_s) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (if_valid && stall) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: expected captures are queued when an ack is
// driven and popped when the instruction slot is sampled on the next cycle.
module tb_if_stage;

  localparam logic [31:0] RESET_PC         = 32'h0000_0000;
  localparam int          IMEM_LATENCY_MAX = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic [5:0]  if_opcode;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp   = 0;
  int   n_err   = 0;
  int   n_fetch = 0;

  if_stage #(
    .RESET_PC         (RESET_PC),
    .IMEM_LATENCY_MAX (IMEM_LATENCY_MAX)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc4         (if_pc4),
    .if_opcode      (if_opcode)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt      (fetch_cnt),
    .stall_cnt      (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_req();
    int k = 0;
    while (!imem_req && k < IMEM_LATENCY_MAX) begin
      step();
      k++;
    end
    check("req_seen", {31'd0, imem_req}, 32'd1);
  endtask

  // one ack cycle on the request at addr; cap says whether the data must land
  task automatic ack_cycle(input logic [31:0] data, input logic redir, input logic [31:0] rpc,
                           input logic stl, input logic [31:0] addr, input logic cap);
    exp_t e;
    check("req_addr", imem_addr, addr);
    imem_ack       = 1'b1;
    imem_rdata     = data;
    redirect_valid = redir;
    redirect_pc    = rpc;
    stall          = stl;
    if (cap) begin
      e.instr = data;
      e.pc4   = addr + 32'd4;
      sb_q.push_back(e);
      n_fetch++;
    end
    step();
    imem_ack       = 1'b0;
    redirect_valid = 1'b0;
    imem_rdata     = 32'h0;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("cap_valid", {31'd0, if_valid}, 32'd1);
      check("cap_instr", if_instr, e.instr);
      check("cap_pc4", if_pc4, e.pc4);
    end else begin
      check("discard_valid", {31'd0, if_valid}, 32'd0);
      check("discard_instr", if_instr, 32'h0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   {31'd0, imem_req}, 32'd0);
    check({tag, "_addr"},  imem_addr, RESET_PC);
    check({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
    check({tag, "_instr"}, if_instr, 32'h0);
    check({tag, "_pc4"},   if_pc4, 32'h0);
  endtask

  initial begin
    @(negedge clk);
    repeat (2) step();
    check_reset_outputs("rst");

    // release: exactly one IDLE cycle, then request at RESET_PC
    rst_n = 1'b1;
    step();
    check("idle_exit_req", {31'd0, imem_req}, 32'd1);
    check("idle_exit_addr", imem_addr, RESET_PC);

    // first ack one cycle later, with stall held so the stage parks in HOLD
    step();
    check("addr_stable", imem_addr, 32'h0);
    ack_cycle(32'h2008_0005, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
    check("opcode_addi", {26'd0, if_opcode}, 32'h0000_0008);
    check("hold_req", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall_instr", if_instr, 32'h2008_0005);
      check("stall_valid", {31'd0, if_valid}, 32'd1);
      check("stall_req", {31'd0, imem_req}, 32'd0);
    end
    stall = 1'b0;
    step();
    check("consume_valid", {31'd0, if_valid}, 32'd0);
    check("resume_req", {31'd0, imem_req}, 32'd1);
    check("resume_addr", imem_addr, 32'h4);

    // plain fetch at 4, then redirect to 0x40 while the request at 8 is pending
    ack_cycle(32'h0109_4020, 1'b0, 32'h0, 1'b0, 32'h4, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    step();
    redirect_valid = 1'b0;
    check("drop_valid", {31'd0, if_valid}, 32'd0);
    check("drop_req", {31'd0, imem_req}, 32'd1);
    check("drop_addr", imem_addr, 32'h8);
    step();
    check("drop_valid2", {31'd0, if_valid}, 32'd0);
    ack_cycle(32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 32'h8, 1'b0);
    check("redir_addr", imem_addr, 32'h40);
    check("redir_req", {31'd0, imem_req}, 32'd1);

    // simultaneous ack and redirect; low target bits must be forced to zero
    ack_cycle(32'h1234_5678, 1'b1, 32'h0000_0083, 1'b0, 32'h40, 1'b0);
    check("same_cyc_addr", imem_addr, 32'h80);

    // redirect out of HOLD while stalled
    ack_cycle(32'h8C43_0010, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    stall          = 1'b0;
    check("hold_redir_valid", {31'd0, if_valid}, 32'd0);
    check("hold_redir_instr", if_instr, 32'h0);
    check("hold_redir_req", {31'd0, imem_req}, 32'd1);

    // PC wrap at the top of the address space
    ack_cycle(32'hAC22_0004, 1'b0, 32'h0, 1'b0, 32'hFFFF_FFFC, 1'b1);
    check("wrap_addr", imem_addr, 32'h0);

    // reset in the middle of an outstanding request, then a late ack in IDLE
    ack_cycle(32'h0000_0020, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst_n      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    n_fetch    = 0;
    check("late_ack_valid", {31'd0, if_valid}, 32'd0);
    check("late_ack_instr", if_instr, 32'h0);
    wait_req();
    check("late_ack_addr", imem_addr, RESET_PC);
    ack_cycle(32'h2008_0007, 1'b0, 32'h0, 1'b0, RESET_PC, 1'b1);

`ifdef IF_PERF_CNT_EN
    check("fetch_cnt", fetch_cnt, 32'(n_fetch));
`endif
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
